// File: rtl/march_response_analyzer_pkg.sv
// march_response_analyzer_pkg: shared op encodings, controller states and default sizes.
package march_response_analyzer_pkg;
  localparam logic MARCH_OP_READ  = 1'b0;
  localparam logic MARCH_OP_WRITE = 1'b1;
  localparam int   RD_LAT_DEF     = 2;
  localparam int   FCW_DEF        = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/exp_data_pipe.sv
// exp_data_pipe: DEPTH-deep valid/data delay line with synchronous flush of the valid bits.
module exp_data_pipe #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);
  logic [DEPTH-1:0]   vld;
  logic [DEPTH*W-1:0] data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld  <= '0;
      data <= '0;
    end else begin
      vld  <= flush ? '0 : DEPTH'({vld, in_vld});
      data <= (DEPTH*W)'({data, in_data});
    end
  assign out_vld  = vld[DEPTH-1];
  assign out_data = data[DEPTH*W-1 -: W];
endmodule

// File: rtl/march_response_analyzer.sv
// march_response_analyzer: issues march ops to memory and logs read mismatches.
// PMBIST_DIAG_LOG_EN enables first-fail address/syndrome capture.
module march_response_analyzer
  import march_response_analyzer_pkg::*;
#(
  parameter int DW     = 8,
  parameter int AW     = 10,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int FCW    = FCW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ts_in,
  input  logic           te_in,
  input  logic           op_vld_in,
  input  logic           op_in,
  input  logic           pol_in,
  input  logic [AW-1:0]  addr_in,
  input  logic [DW-1:0]  bg_in,
  output logic           mem_ce,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  output logic           busy_out,
  output logic           done_out,
  output logic           fail_out,
  output logic [FCW-1:0] fail_cnt_out,
  output logic [AW-1:0]  ff_addr_out,
  output logic [DW-1:0]  ff_syn_out
);
`ifdef PMBIST_DIAG_LOG_EN
  localparam int PW = AW + DW;
`else
  localparam int PW = DW;
`endif
  state_t        state;
  logic [2:0]    drain_cnt;
  logic          issue;
  logic          x_vld;
  logic [PW-1:0] pipe_in;
  logic [PW-1:0] x_data;
  logic [DW-1:0] x_exp;
  logic          mis;
  assign issue    = state == RUN && op_vld_in;
  assign busy_out = state == RUN || state == DRAIN;
  assign done_out = state == DONE;
`ifdef PMBIST_DIAG_LOG_EN
  assign pipe_in = {mem_addr, mem_wdata};
`else
  assign pipe_in = mem_wdata;
`endif
  // entries enter from the registered mem_ce cycle so they exit with mem_rdata
  exp_data_pipe #(.W(PW), .DEPTH(RD_LAT)) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush   (ts_in),
    .in_vld  (mem_ce && mem_we == MARCH_OP_READ),
    .in_data (pipe_in),
    .out_vld (x_vld),
    .out_data(x_data)
  );
  assign x_exp = x_data[DW-1:0];
  assign mis   = x_vld && mem_rdata != x_exp;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      drain_cnt    <= '0;
      mem_ce       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      fail_out     <= 1'b0;
      fail_cnt_out <= '0;
    end else if (ts_in) begin
      state        <= RUN;
      drain_cnt    <= '0;
      mem_ce       <= 1'b0;
      mem_we       <= 1'b0;
      fail_out     <= 1'b0;
      fail_cnt_out <= '0;
    end else begin
      mem_ce <= issue;
      mem_we <= issue && op_in == MARCH_OP_WRITE;
      if (issue) begin
        mem_addr  <= addr_in;
        mem_wdata <= pol_in ? ~bg_in : bg_in;
      end
      if (state == RUN && te_in) begin
        state     <= DRAIN;
        drain_cnt <= 3'(RD_LAT + 1);
      end
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt - 3'd1;
        if (drain_cnt == 3'd1) state <= DONE;
      end
      if (mis) begin
        fail_out     <= 1'b1;
        fail_cnt_out <= fail_cnt_out + FCW'(fail_cnt_out != '1);
      end
    end
`ifdef PMBIST_DIAG_LOG_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ff_addr_out <= '0;
      ff_syn_out  <= '0;
    end else if (ts_in) begin
      ff_addr_out <= '0;
      ff_syn_out  <= '0;
    end else if (mis && !fail_out) begin
      ff_addr_out <= x_data[PW-1:DW];
      ff_syn_out  <= x_exp ^ mem_rdata;
    end
`else
  assign ff_addr_out = '0;
  assign ff_syn_out  = '0;
`endif
endmodule
